// File: rtl/chan_fifo_reader_mf.sv
// Per-channel TX packet reader: parses header/timestamp from a show-ahead FIFO, gates launch on
// time, carrier sense and matched-filter trigger, then streams QI16 or QI8 samples to the tx chain.
module chan_fifo_reader_mf #(
    parameter int SAMPLE_W  = 16,
    parameter int PAYLOAD_W = 7,
    parameter int TS_W      = 32,
    parameter int CNT_W     = 16
) (
    input  logic                tx_clock,
    input  logic                reset,
    input  logic                tx_strobe,
    input  logic [TS_W-1:0]     timestamp_clock,
    input  logic [3:0]          samples_format,
    input  logic [31:0]         fifodata,
    input  logic                pkt_waiting,
    output logic                rdreq,
    output logic                skip,
    output logic [SAMPLE_W-1:0] tx_i,
    output logic [SAMPLE_W-1:0] tx_q,
    output logic                tx_empty,
    output logic                underrun,
    output logic                burst,
    input  logic [31:0]         rssi,
    input  logic [31:0]         threshhold,
    input  logic [31:0]         cs_timeout,
    input  logic                mf_match,
    input  logic                late_policy,
    output logic [CNT_W-1:0]    pkt_sent,
    output logic [CNT_W-1:0]    pkt_dropped
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_HEADER, ST_TIMESTAMP, ST_MF_WAIT, ST_CS_WAIT,
        ST_WAIT, ST_WAITSTROBE, ST_SEND, ST_HALF
    } state_t;

    state_t                state_q;
    logic                  rdreq_q, skip_q, tx_empty_q, underrun_q, burst_q, trash_q;
    logic [SAMPLE_W-1:0]   tx_i_q, tx_q_q;
    logic [CNT_W-1:0]      sent_q, dropped_q;
    logic                  rssi_flag_q, mf_flag_q, half_q;
    logic [PAYLOAD_W-1:0]  len_q, read_len_q;
    logic [TS_W-1:0]       ts_q;
    logic [31:0]           gate_cnt_q;
    logic [15:0]           hi_q;

    logic                  sob, eob;
    logic [TS_W-1:0]       ts_delta_d;
    logic                  gate_expire_d;

    assign sob = fifodata[28];
    assign eob = fifodata[27];
    // Modular difference: MSB set means the launch time is already in the past, even across wrap.
    assign ts_delta_d    = ts_q - timestamp_clock;
    assign gate_expire_d = (cs_timeout != 32'd0) && (gate_cnt_q == cs_timeout - 32'd1);

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rdreq_q     <= 1'b0;
            skip_q      <= 1'b0;
            tx_i_q      <= '0;
            tx_q_q      <= '0;
            tx_empty_q  <= 1'b1;
            underrun_q  <= 1'b0;
            burst_q     <= 1'b0;
            trash_q     <= 1'b0;
            sent_q      <= '0;
            dropped_q   <= '0;
            rssi_flag_q <= 1'b0;
            mf_flag_q   <= 1'b0;
            half_q      <= 1'b0;
            len_q       <= '0;
            read_len_q  <= '0;
            ts_q        <= '0;
            gate_cnt_q  <= '0;
            hi_q        <= '0;
        end else begin
            skip_q  <= 1'b0;
            rdreq_q <= 1'b0;
            if (tx_strobe && state_q != ST_SEND && state_q != ST_HALF)
                tx_empty_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (pkt_waiting) begin
                        rdreq_q    <= 1'b1;
                        underrun_q <= 1'b0;
                        state_q    <= ST_HEADER;
                    end else if (burst_q) begin
                        underrun_q <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (sob && eob)  burst_q <= 1'b0;
                    else if (sob)    burst_q <= 1'b1;
                    else if (eob)    burst_q <= 1'b0;
                    // After a drop, the remainder of that burst is discarded until a fresh SOB.
                    if (trash_q && !sob) begin
                        skip_q    <= 1'b1;
                        dropped_q <= dropped_q + 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        if (sob) begin
                            rssi_flag_q <= fifodata[26];
                            mf_flag_q   <= fifodata[25];
                        end
                        len_q      <= fifodata[PAYLOAD_W+1:2];
                        read_len_q <= '0;
                        rdreq_q    <= 1'b1;
                        state_q    <= ST_TIMESTAMP;
                    end
                end
                ST_TIMESTAMP: begin
                    ts_q       <= fifodata[TS_W-1:0];
                    gate_cnt_q <= '0;
                    if (mf_flag_q)        state_q <= ST_MF_WAIT;
                    else if (rssi_flag_q) state_q <= ST_CS_WAIT;
                    else                  state_q <= ST_WAIT;
                end
                ST_MF_WAIT: begin
                    gate_cnt_q <= gate_cnt_q + 32'd1;
                    if (mf_match) begin
                        gate_cnt_q <= '0;
                        state_q    <= rssi_flag_q ? ST_CS_WAIT : ST_WAIT;
                    end else if (gate_expire_d) begin
                        skip_q    <= 1'b1;
                        trash_q   <= 1'b1;
                        dropped_q <= dropped_q + 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CS_WAIT: begin
                    gate_cnt_q <= gate_cnt_q + 32'd1;
                    if (rssi <= threshhold) begin
                        state_q <= ST_WAIT;
                    end else if (gate_expire_d) begin
                        skip_q    <= 1'b1;
                        trash_q   <= 1'b1;
                        dropped_q <= dropped_q + 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ts_q == '1 || ts_delta_d == '0) begin
                        trash_q <= 1'b0;
                        state_q <= ST_WAITSTROBE;
                    end else if (ts_delta_d[TS_W-1]) begin
                        if (late_policy) begin
                            trash_q <= 1'b0;
                            state_q <= ST_WAITSTROBE;
                        end else begin
                            skip_q    <= 1'b1;
                            trash_q   <= 1'b1;
                            dropped_q <= dropped_q + 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_WAITSTROBE: begin
                    if (read_len_q == len_q && !half_q) begin
                        skip_q  <= 1'b1;
                        sent_q  <= sent_q + 1'b1;
                        state_q <= ST_IDLE;
                    end else if (tx_strobe) begin
                        if (half_q) begin
                            state_q <= ST_HALF;
                        end else begin
                            rdreq_q <= 1'b1;
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    read_len_q <= read_len_q + 1'b1;
                    tx_empty_q <= 1'b0;
                    if (samples_format == 4'd1) begin
                        tx_i_q <= {fifodata[7:0],  {(SAMPLE_W-8){1'b0}}};
                        tx_q_q <= {fifodata[15:8], {(SAMPLE_W-8){1'b0}}};
                        hi_q   <= fifodata[31:16];
                        half_q <= 1'b1;
                    end else begin
                        tx_i_q <= SAMPLE_W'($signed(fifodata[15:0]));
                        tx_q_q <= SAMPLE_W'($signed(fifodata[31:16]));
                    end
                    state_q <= ST_WAITSTROBE;
                end
                ST_HALF: begin
                    tx_i_q     <= {hi_q[7:0],  {(SAMPLE_W-8){1'b0}}};
                    tx_q_q     <= {hi_q[15:8], {(SAMPLE_W-8){1'b0}}};
                    half_q     <= 1'b0;
                    tx_empty_q <= 1'b0;
                    state_q    <= ST_WAITSTROBE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdreq       = rdreq_q;
    assign skip        = skip_q;
    assign tx_i        = tx_i_q;
    assign tx_q        = tx_q_q;
    assign tx_empty    = tx_empty_q;
    assign underrun    = underrun_q;
    assign burst       = burst_q;
    assign pkt_sent    = sent_q;
    assign pkt_dropped = dropped_q;

endmodule

// File: tb/tb_chan_fifo_reader_mf.sv
// Directed bench for chan_fifo_reader_mf with a show-ahead packet FIFO model.
module tb_chan_fifo_reader_mf;

    logic        tx_clock = 1'b0;
    logic        reset, tx_strobe, pkt_waiting, mf_match, late_policy;
    logic        rdreq, skip, tx_empty, underrun, burst;
    logic [31:0] ts_clk, fifodata, rssi, threshhold, cs_timeout;
    logic [3:0]  samples_format;
    logic [15:0] tx_i, tx_q, pkt_sent, pkt_dropped;

    always #5 tx_clock = ~tx_clock;

    chan_fifo_reader_mf dut (
        .tx_clock(tx_clock), .reset(reset), .tx_strobe(tx_strobe),
        .timestamp_clock(ts_clk), .samples_format(samples_format),
        .fifodata(fifodata), .pkt_waiting(pkt_waiting), .rdreq(rdreq), .skip(skip),
        .tx_i(tx_i), .tx_q(tx_q), .tx_empty(tx_empty), .underrun(underrun), .burst(burst),
        .rssi(rssi), .threshhold(threshhold), .cs_timeout(cs_timeout),
        .mf_match(mf_match), .late_policy(late_policy),
        .pkt_sent(pkt_sent), .pkt_dropped(pkt_dropped)
    );

    int          n_chk = 0, n_err = 0;
    logic [31:0] fq[$];
    logic [31:0] pay[$];
    logic [31:0] smp[$];
    int          plen[$];
    int          ptr = 0, cyc = 0, skips = 0, mf_at = -1, rssi_at = -1, pre_mf_smp = 0;
    bit          started = 0, strobe_en = 0, got_first = 0;
    logic        prev_empty = 1'b1;
    logic [31:0] first_ts, rssi_new;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void drive_fifo();
        pkt_waiting = (plen.size() > (started ? 1 : 0));
        fifodata    = (ptr < fq.size()) ? fq[ptr] : 32'h0;
    endfunction

    task automatic tick();
        logic rd, sk;
        rd = rdreq;
        sk = skip;
        @(posedge tx_clock);
        #1;
        cyc++;
        ts_clk = ts_clk + 32'd1;
        if (sk && plen.size() > 0) begin
            repeat (plen[0]) void'(fq.pop_front());
            void'(plen.pop_front());
            ptr     = 0;
            started = 0;
        end else if (rd) begin
            if (ptr == 0) started = 1;
            ptr++;
        end
        if (sk) skips++;
        if (!tx_empty && prev_empty) begin
            smp.push_back({tx_i, tx_q});
            if (!got_first) begin
                got_first = 1;
                first_ts  = ts_clk;
            end
        end
        prev_empty = tx_empty;
        tx_strobe  = strobe_en && (cyc % 4 == 0);
        drive_fifo();
    endtask

    task automatic add_pkt(input logic [31:0] flags, input int len, input logic [31:0] ts);
        fq.push_back(flags | (32'(len) << 2));
        fq.push_back(ts);
        foreach (pay[k]) fq.push_back(pay[k]);
        plen.push_back(len + 2);
        pay.delete();
        drive_fifo();
    endtask

    // Runs until either packet counter moves; returns cycles used (-1 on budget expiry).
    task automatic run_pkt(input int max, output int used);
        int s0;
        s0   = int'(pkt_sent) + int'(pkt_dropped);
        used = -1;
        for (int k = 0; k < max; k++) begin
            mf_match = (k == mf_at);
            if (k == mf_at) pre_mf_smp = smp.size();
            if (k == rssi_at) rssi = rssi_new;
            tick();
            if (int'(pkt_sent) + int'(pkt_dropped) != s0) begin
                used = k + 1;
                break;
            end
        end
        mf_match = 1'b0;
        mf_at    = -1;
        rssi_at  = -1;
        chk("pkt_done_in_budget", used > 0, 1);
    endtask

    function automatic logic [31:0] smp_at(input int k);
        return (k < smp.size()) ? smp[k] : 32'hDEADBEEF;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int used;
        reset = 1'b1; tx_strobe = 1'b0; mf_match = 1'b0; late_policy = 1'b0;
        ts_clk = 32'h1000; samples_format = 4'd0; rssi = 0; threshhold = 0; cs_timeout = 0;
        drive_fifo();
        repeat (3) tick();
        chk("rst_rdreq", rdreq, 0);
        chk("rst_skip", skip, 0);
        chk("rst_tx_iq", {tx_i, tx_q}, 0);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_burst", burst, 0);
        chk("rst_counters", {pkt_sent, pkt_dropped}, 0);
        reset = 1'b0;
        strobe_en = 1;
        tick();

        // QI16, 4 words, launch immediately
        pay = '{32'h00020001, 32'h80048003, 32'h00060005, 32'h7FF8FFF7};
        smp.delete(); skips = 0;
        add_pkt(32'h18000000, 4, 32'hFFFFFFFF);
        run_pkt(200, used);
        chk("qi16_count", smp.size(), 4);
        chk("qi16_s0", smp_at(0), 32'h00010002);
        chk("qi16_s1", smp_at(1), 32'h80038004);
        chk("qi16_s2", smp_at(2), 32'h00050006);
        chk("qi16_s3", smp_at(3), 32'hFFF77FF8);
        repeat (8) tick();
        chk("qi16_skip_pulses", skips, 1);
        chk("qi16_sent", pkt_sent, 1);
        chk("qi16_empty_after", tx_empty, 1);
        chk("qi16_burst", burst, 0);

        // QI8 unpacking, left-justified
        samples_format = 4'd1;
        pay = '{32'h44332211, 32'h88776655};
        smp.delete();
        add_pkt(32'h18000000, 2, 32'hFFFFFFFF);
        run_pkt(200, used);
        chk("qi8_count", smp.size(), 4);
        chk("qi8_s0", smp_at(0), 32'h11002200);
        chk("qi8_s1", smp_at(1), 32'h33004400);
        chk("qi8_s2", smp_at(2), 32'h55006600);
        chk("qi8_s3", smp_at(3), 32'h77008800);
        chk("qi8_sent", pkt_sent, 2);
        samples_format = 4'd0;
        repeat (4) tick();

        // Late packet dropped, following non-SOB packet trashed, then late_policy=1 sends
        smp.delete();
        pay = '{32'h11111111};
        add_pkt(32'h18000000, 1, ts_clk - 32'd5);
        run_pkt(100, used);
        chk("late_dropped", pkt_dropped, 1);
        pay = '{32'h22222222};
        add_pkt(32'h08000000, 1, 32'hFFFFFFFF);
        run_pkt(100, used);
        chk("trash_dropped", pkt_dropped, 2);
        chk("trash_no_samples", smp.size(), 0);
        late_policy = 1'b1;
        pay = '{32'h12345678};
        add_pkt(32'h18000000, 1, ts_clk - 32'd5);
        run_pkt(100, used);
        chk("late_send_sent", pkt_sent, 3);
        chk("late_send_sample", smp_at(0), 32'h56781234);
        late_policy = 1'b0;
        repeat (4) tick();

        // Timestamp wrap: target is 32 ticks ahead across the rollover
        ts_clk = 32'hFFFFFFF0;
        got_first = 0;
        pay = '{32'h0000ABCD};
        add_pkt(32'h18000000, 1, 32'h00000010);
        run_pkt(200, used);
        chk("wrap_sent", pkt_sent, 4);
        chk("wrap_not_dropped", pkt_dropped, 2);
        chk("wrap_wait_cycles", used >= 32 && used <= 45, 1);
        chk("wrap_launch_time", (first_ts - 32'h10) < 32'd8, 1);
        repeat (4) tick();

        // Carrier sense timeout, then carrier clears at cycle 40
        rssi = 100; threshhold = 50; cs_timeout = 100;
        pay = '{32'h00000001};
        add_pkt(32'h1C000000, 1, 32'hFFFFFFFF);
        run_pkt(300, used);
        chk("cs_timeout_dropped", pkt_dropped, 3);
        chk("cs_timeout_cycles", used >= 101 && used <= 106, 1);
        pay = '{32'h00000002};
        add_pkt(32'h1C000000, 1, 32'hFFFFFFFF);
        rssi_at = 40; rssi_new = 10;
        run_pkt(300, used);
        chk("cs_clear_sent", pkt_sent, 5);
        chk("cs_clear_cycles", used >= 42 && used <= 50, 1);
        chk("cs_clear_not_dropped", pkt_dropped, 3);
        cs_timeout = 0;
        repeat (4) tick();

        // Matched-filter trigger, then underrun while burst is open
        smp.delete();
        pay = '{32'h00040003, 32'h00060005};
        add_pkt(32'h12000000, 2, 32'hFFFFFFFF);
        mf_at = 20;
        run_pkt(200, used);
        chk("mf_no_early_sample", pre_mf_smp, 0);
        chk("mf_sent", pkt_sent, 6);
        chk("mf_samples", smp.size(), 2);
        chk("mf_burst_open", burst, 1);
        repeat (3) tick();
        chk("underrun_set", underrun, 1);
        repeat (3) tick();
        chk("underrun_sticky", underrun, 1);
        pay = '{32'h00080007};
        add_pkt(32'h08000000, 1, 32'hFFFFFFFF);
        repeat (2) tick();
        chk("underrun_cleared", underrun, 0);
        mf_at = 5;
        run_pkt(200, used);
        chk("mf_eob_sent", pkt_sent, 7);
        chk("mf_eob_burst_closed", burst, 0);

        // Zero-length packet counts as sent with no samples
        smp.delete();
        add_pkt(32'h18000000, 0, 32'hFFFFFFFF);
        run_pkt(100, used);
        chk("len0_sent", pkt_sent, 8);
        chk("len0_no_samples", smp.size(), 0);

        // Reset while a packet waits for its launch time
        pay = '{32'h00000009};
        add_pkt(32'h10000000, 1, ts_clk + 32'd1000);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("midrst_rdreq", rdreq, 0);
        chk("midrst_tx_empty", tx_empty, 1);
        chk("midrst_burst", burst, 0);
        chk("midrst_counters", {pkt_sent, pkt_dropped}, 0);
        fq.delete(); plen.delete(); ptr = 0; started = 0;
        drive_fifo();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
